// File: rtl/quet_led_7doan_pkg.sv
// quet_pkg: shared state type and default timing for the seven-segment scanner.
// Contents: state_t (LOAD, ON, BLANK) and default N_DIGITS / DIGIT_CYC / GAP_CYC.
package quet_pkg;
    typedef enum logic [1:0] {LOAD, ON, BLANK} state_t;
    localparam int DEF_N_DIGITS  = 8;
    localparam int DEF_DIGIT_CYC = 50000;
    localparam int DEF_GAP_CYC   = 500;
endpackage

// File: rtl/quet_led_7doan_if.sv
// quet_led_7doan_if: scanner bus between the host logic and the seven-segment decoder side.
// Host -> scanner: data (packed hex), dp_in, digit_en, lz_en.
// Scanner -> decoder/display: so_gma, ena, dp, sel_led, frame_done.
interface quet_led_7doan_if
    import quet_pkg::*;
#(
    parameter int N = DEF_N_DIGITS
);
    logic [4*N-1:0] data;
    logic [N-1:0]   dp_in;
    logic [N-1:0]   digit_en;
    logic           lz_en;
    logic [3:0]     so_gma;
    logic           ena;
    logic           dp;
    logic [N-1:0]   sel_led;
    logic           frame_done;
    modport master (output data, dp_in, digit_en, lz_en, input so_gma, ena, dp, sel_led, frame_done);
    modport slave  (input data, dp_in, digit_en, lz_en, output so_gma, ena, dp, sel_led, frame_done);
endinterface

// File: rtl/quet_led_7doan_dem_tick.sv
// dem_tick: loadable cycle counter with terminal-count flag, shared by the ON and BLANK states.
// Ports: ckht clock, rst_n async active-low reset, load_i clears the count to 0,
// term_i terminal value for the current state, tc_o high while count equals term_i.
module dem_tick #(
    parameter int W = 2
) (
    input  logic         ckht,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] term_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tc_o  = cnt_q == term_i;
    assign cnt_d = load_i ? '0 : cnt_q + 1'b1;
    always_ff @(posedge ckht or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
endmodule

// File: rtl/quet_led_7doan.sv
// quet_led_7doan: time-multiplexed N-digit seven-segment scanner with blanking and leading-zero suppression.
// Ports: ckht clock, rst_n async active-low reset, bus (slave) carrying the snapshot inputs
// data/dp_in/digit_en/lz_en and the Moore outputs so_gma/ena/dp/sel_led/frame_done.
module quet_led_7doan
    import quet_pkg::*;
#(
    parameter int N_DIGITS  = DEF_N_DIGITS,
    parameter int DIGIT_CYC = DEF_DIGIT_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic            ckht,
    input  logic            rst_n,
    quet_led_7doan_if.slave bus
);
    localparam int IW = $clog2(N_DIGITS);
    localparam int CW = $clog2((DIGIT_CYC > GAP_CYC ? DIGIT_CYC : GAP_CYC) + 1);
    localparam logic [CW-1:0] T_ON  = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] T_GAP = CW'(GAP_CYC == 0 ? 0 : GAP_CYC - 1);
    localparam logic [IW-1:0] LAST  = IW'(N_DIGITS - 1);
    state_t                  state_q;
    logic [IW-1:0]           idx_q;
    logic                    live_q;
    logic [4*N_DIGITS-1:0]   snap_data_q;
    logic [N_DIGITS-1:0]     snap_dp_q, snap_en_q;
    logic                    snap_lz_q;
    logic                    tc, last, on;
    logic [N_DIGITS-1:0]     nz, lzb;
    assign last = idx_q == LAST;
    assign on   = state_q == ON;
    dem_tick #(.W(CW)) u_tick (
        .ckht   (ckht),
        .rst_n  (rst_n),
        .load_i (state_q == LOAD || tc),
        .term_i (state_q == BLANK ? T_GAP : T_ON),
        .tc_o   (tc)
    );
    // live_q keeps outputs quiet during reset; the first LOAD cycle is the one after the first edge.
    always_ff @(posedge ckht or negedge rst_n)
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            live_q      <= 1'b0;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
            snap_en_q   <= '0;
            snap_lz_q   <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                LOAD: if (live_q) begin
                    snap_data_q <= bus.data;
                    snap_dp_q   <= bus.dp_in;
                    snap_en_q   <= bus.digit_en;
                    snap_lz_q   <= bus.lz_en;
                    idx_q       <= '0;
                    state_q     <= ON;
                end
                ON: if (tc) begin
                    if (GAP_CYC > 0) state_q <= BLANK;
                    else begin
                        state_q <= last ? LOAD : ON;
                        idx_q   <= last ? idx_q : idx_q + 1'b1;
                    end
                end
                BLANK: if (tc) begin
                    state_q <= last ? LOAD : ON;
                    idx_q   <= last ? idx_q : idx_q + 1'b1;
                end
                default: state_q <= LOAD;
            endcase
        end
    // nz[i]: some snapshot digit at position i or above is non-zero (prefix-OR from the top).
    always_comb begin
        nz = '0;
        nz[N_DIGITS-1] = |snap_data_q[4*N_DIGITS-1 -: 4];
        for (int i = N_DIGITS - 2; i >= 0; i--) nz[i] = nz[i+1] | (|snap_data_q[4*i +: 4]);
    end
    assign lzb = {N_DIGITS{snap_lz_q}} & ~nz & ~N_DIGITS'(1);
    assign bus.so_gma     = on ? snap_data_q[{idx_q, 2'b00} +: 4] : 4'h0;
    assign bus.dp         = on && snap_dp_q[idx_q];
    assign bus.ena        = on && snap_en_q[idx_q] && !lzb[idx_q];
    assign bus.sel_led    = on ? N_DIGITS'(1) << idx_q : '0;
    assign bus.frame_done = state_q == LOAD && live_q;
endmodule
